serial_add_ctrl: RTL and testbench

//  Sequencer that time-shares one 1-bit fulladder (a, b, c -> sum, carry) to add two

---
 rtl/serial_add_ctrl_if.sv | 35 +++
 rtl/serial_add_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a datapath and the bit-serial adder sequencer.
// Optional macro SERIAL_ADD_SUB_EN adds the 'sub' request bit.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    // Requesting datapath side
    modport master (
        output start, a_in, b_in, cin,
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        input  busy, done, result, cout
    );

    // Sequencer side
    modport slave (
        input  start, a_in, b_in, cin,
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full adder, one operand bit pair per clock,
// LSB first. Result and carry-out are held until the next accepted start.
// Optional macro SERIAL_ADD_SUB_EN: a 'sub' request bit turns the op into a - b
// (B inverted, carry-in forced to 1; cout==1 means no borrow).
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             fa_a, fa_b, fa_sum, fa_carry;
    logic [WIDTH-1:0] result_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // The single shared full adder, fed from the shift-register LSBs and stored carry
    assign fa_a     = a_sr_reg[0];
    assign fa_b     = b_sr_reg[0];
    assign fa_sum   = fa_a ^ fa_b ^ carry_reg;
    assign fa_carry = (fa_a & fa_b) | (carry_reg & (fa_a ^ fa_b));

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign result_shift[gi] = result_reg[gi + 1];
        end
    endgenerate
    assign result_shift[WIDTH-1] = fa_sum;

    // Operand conditioning at load time: subtraction is a + ~b + 1
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign c_load = bus.sub | bus.cin;
`else
    assign b_load = bus.b_in;
    assign c_load = bus.cin;
`endif

    // Next-state and datapath update; DONE accepts a start exactly like IDLE
    always_comb begin
        state_next  = state_reg;
        a_sr_next   = a_sr_reg;
        b_sr_next   = b_sr_reg;
        result_next = result_reg;
        count_next  = count_reg;
        carry_next  = carry_reg;
        cout_next   = cout_reg;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sr_next  = bus.a_in;
                    b_sr_next  = b_load;
                    carry_next = c_load;
                    count_next = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                a_sr_next   = a_sr_reg >> 1;
                b_sr_next   = b_sr_reg >> 1;
                carry_next  = fa_carry;
                result_next = result_shift;
                count_next  = count_reg + CNT_W'(1);
                if (count_reg == CNT_W'(WIDTH - 1)) begin
                    cout_next  = fa_carry;
                    state_next = DONE;
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            result_reg <= '0;
            count_reg  <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_sr_reg   <= a_sr_next;
            b_sr_reg   <= b_sr_next;
            result_reg <= result_next;
            count_reg  <= count_next;
            carry_reg  <= carry_next;
            cout_reg   <= cout_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed ops checked against hand-computed literals, plus a
// cycle-level behavioural model (countdown + integer add) compared on every cycle.
// Build with SERIAL_ADD_SUB_EN defined to also exercise subtraction.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();

    serial_add_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cmp_count  = 0;
    int fail_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_rem     = 0;
    logic [WIDTH:0]   m_pending = '0;
    logic [WIDTH-1:0] m_result  = '0;
    logic             m_cout    = 1'b0;
    logic             m_done    = 1'b0;
    logic             m_busy    = 1'b0;
    bit               m_valid   = 1'b0;

    function automatic logic [WIDTH:0] model_sum(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic c, input logic s);
        logic [WIDTH-1:0] nb;
        nb = ~b;
        if (s) return (WIDTH+1)'(a) + (WIDTH+1)'(nb) + (WIDTH+1)'(1);
        return (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c);
    endfunction

    logic sub_now;
`ifdef SERIAL_ADD_SUB_EN
    assign sub_now = bus.sub;
`else
    assign sub_now = 1'b0;
`endif

    // Op accepted when idle: WIDTH cycles busy, then done with the sum committed
    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem    = 0;
            m_result = '0;
            m_cout   = 1'b0;
            m_done   = 1'b0;
            m_valid  = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    {m_cout, m_result} = m_pending;
                end
            end else if (bus.start) begin
                m_rem     = WIDTH;
                m_pending = model_sum(bus.a_in, bus.b_in, bus.cin, sub_now);
            end
        end
        m_busy = (m_rem > 0);
    end

    // Per-cycle compare; result/cout are only meaningful while not busy
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_busy", 32'(bus.busy), 32'(m_busy));
            check("cyc_done", 32'(bus.done), 32'(m_done));
            if (!m_busy) begin
                check("cyc_result", 32'(bus.result), 32'(m_result));
                check("cyc_cout", 32'(bus.cout), 32'(m_cout));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic c, input logic s);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = ~a;      // operands are don't-care after the accepting edge
        bus.b_in  = ~b;
        bus.cin   = ~c;
    endtask

    // Waits for done (bounded); optionally pulses start with junk operands mid-run
    task automatic wait_done(input int glitch_at, output int n);
        n = 1;
        while (!bus.done && n < 40) begin
            if (n == glitch_at) begin
                bus.start = 1'b1;
                bus.a_in  = 8'hAA;
                bus.b_in  = 8'h55;
                bus.cin   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] er, input logic ec);
        check({tag, "_result"}, 32'(bus.result), 32'(er));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_model_result"}, 32'(m_result), 32'(er));
        check({tag, "_model_cout"}, 32'(m_cout), 32'(ec));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input int glitch_at,
                          input logic [WIDTH-1:0] er, input logic ec);
        int n;
        @(negedge clk);
        issue(a, b, c, s);
        wait_done(glitch_at, n);
        check({tag, "_latency"}, 32'(n), 32'(WIDTH + 1));
        check_result(tag, er, ec);
        $display("op %s: a=0x%0h b=0x%0h cin=%0d sub=%0d -> result=0x%0h cout=%0d",
                 tag, a, b, c, s, bus.result, bus.cout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dcount;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        // 1. reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        $display("reset: busy=%0d done=%0d result=0x%0h cout=%0d", bus.busy, bus.done, bus.result, bus.cout);
        rst_n = 1'b1;

        // 2. basic add, 3. wrap cases, plus a few more directed vectors
        run_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 0, 8'h96, 1'b0);
        run_op("wrap1", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1);
        run_op("wrap2", 8'hFF, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1);
        run_op("zero",  8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0);
        run_op("alt",   8'hA5, 8'h5A, 1'b1, 1'b0, 0, 8'h00, 1'b1);
        run_op("half",  8'h7F, 8'h01, 1'b0, 1'b0, 0, 8'h80, 1'b0);
        run_op("mix",   8'h23, 8'h45, 1'b1, 1'b0, 0, 8'h69, 1'b0);

        // 4a. start pulsed during RUN is ignored
        run_op("ignore", 8'h12, 8'h34, 1'b0, 1'b0, 3, 8'h46, 1'b0);

        // 4b. back-to-back: start held in the DONE cycle
        run_op("b2b_first", 8'h01, 8'h02, 1'b0, 1'b0, 0, 8'h03, 1'b0);
        issue(8'h80, 8'h80, 1'b1, 1'b0);
        check("b2b_no_idle_busy", 32'(bus.busy), 32'd1);
        wait_done(0, n);
        check("b2b_latency", 32'(n), 32'(WIDTH + 1));
        check_result("b2b_second", 8'h01, 1'b1);
        $display("op b2b_second: a=0x80 b=0x80 cin=1 -> result=0x%0h cout=%0d", bus.result, bus.cout);

        // 5. reset on the 4th RUN cycle aborts the op
        @(negedge clk);
        issue(8'h0F, 8'h0F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        dcount = 0;
        repeat (WIDTH + 3) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        $display("abort: done pulses after reset=%0d result=0x%0h", dcount, bus.result);

        // recovery after abort
        run_op("recover", 8'h10, 8'h20, 1'b0, 1'b0, 0, 8'h30, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        // 6. subtraction
        run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 0, 8'h0F, 1'b1);
        run_op("sub2", 8'h00, 8'h01, 1'b1, 1'b1, 0, 8'hFF, 1'b0);
        run_op("sub0", 8'h10, 8'h01, 1'b1, 1'b0, 0, 8'h12, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
